// File: rtl/dma_pkt_wr_64to32.sv
// DMA write stage: drains LEN 64b words from a FWFT FIFO and writes each as two 32b memory writes.
// Optional build macro DMA_WR_BSWAP_EN byte-reverses every 32b write word.
module dma_pkt_wr_64to32 #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LEN_W  = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic [LEN_W-1:0]  i_len,
    input  logic [63:0]       i_fifo_dout,
    input  logic              i_fifo_empty,
    output logic              o_fifo_rd_en,
    output logic              o_mem_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [31:0]       o_mem_wdata,
    input  logic              i_mem_gnt,
    output logic              o_busy,
    output logic              o_done,
    output logic [LEN_W-1:0]  o_words_done
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWrLo,
        StWrHi,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic [LEN_W-1:0]  remain_q, remain_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic [31:0]       hold_hi_q, hold_hi_d;
    logic              req_q, req_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              unused_addr_lsb;

    // Byte address is word aligned; the two low bits are dropped at latch time.
    assign unused_addr_lsb = ^i_base_addr[1:0];

`ifdef DMA_WR_BSWAP_EN
    function automatic logic [31:0] wr_fmt(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction
`else
    function automatic logic [31:0] wr_fmt(input logic [31:0] w);
        return w;
    endfunction
`endif

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        remain_d     = remain_q;
        words_d      = words_q;
        hold_hi_d    = hold_hi_q;
        req_d        = req_q;
        wdata_d      = wdata_q;
        o_fifo_rd_en = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    cur_d    = {i_base_addr[ADDR_W-1:2], 2'b00};
                    remain_d = i_len;
                    words_d  = '0;
                    state_d  = (i_len != '0) ? StFetch : StDone;
                end
            end
            StFetch: begin
                // Low half goes straight to the write register; only the high half is held.
                if (!i_fifo_empty) begin
                    o_fifo_rd_en = 1'b1;
                    hold_hi_d    = i_fifo_dout[63:32];
                    wdata_d      = wr_fmt(i_fifo_dout[31:0]);
                    req_d        = 1'b1;
                    state_d      = StWrLo;
                end
            end
            StWrLo: begin
                if (i_mem_gnt) begin
                    cur_d   = cur_q + ADDR_W'(4);
                    wdata_d = wr_fmt(hold_hi_q);
                    state_d = StWrHi;
                end
            end
            StWrHi: begin
                if (i_mem_gnt) begin
                    cur_d    = cur_q + ADDR_W'(4);
                    words_d  = words_q + LEN_W'(1);
                    remain_d = remain_q - LEN_W'(1);
                    req_d    = 1'b0;
                    state_d  = (remain_q == LEN_W'(1)) ? StDone : StFetch;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cur_q     <= '0;
            remain_q  <= '0;
            words_q   <= '0;
            hold_hi_q <= '0;
            req_q     <= 1'b0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            remain_q  <= remain_d;
            words_q   <= words_d;
            hold_hi_q <= hold_hi_d;
            req_q     <= req_d;
            wdata_q   <= wdata_d;
        end
    end

    assign o_mem_req    = req_q;
    assign o_mem_addr   = cur_q;
    assign o_mem_wdata  = wdata_q;
    assign o_busy       = (state_q != StIdle);
    assign o_done       = (state_q == StDone);
    assign o_words_done = words_q;

endmodule

// File: tb/tb_dma_pkt_wr_64to32.sv
// Directed bench for dma_pkt_wr_64to32: FIFO and memory modelled with queues.
// Define DMA_WR_BSWAP_EN for both bench and RTL to check the byte-swapped build.
module tb_dma_pkt_wr_64to32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic [31:0] i_base_addr = '0;
    logic [9:0]  i_len = '0;
    logic [63:0] i_fifo_dout = '0;
    logic        i_fifo_empty = 1'b1;
    logic        o_fifo_rd_en;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_gnt = 1'b1;
    logic        o_busy;
    logic        o_done;
    logic [9:0]  o_words_done;

    dma_pkt_wr_64to32 #(.ADDR_W(32), .LEN_W(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_base_addr  (i_base_addr),
        .i_len        (i_len),
        .i_fifo_dout  (i_fifo_dout),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_rd_en (o_fifo_rd_en),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_gnt    (i_mem_gnt),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_words_done (o_words_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int pops = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int start_cyc = 0;
    int rd_empty_err = 0;
    logic [63:0] fifo_q[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    localparam logic [63:0] W0 = 64'h1122334455667788;
    localparam logic [63:0] W1 = 64'hA1A2A3A4B1B2B3B4;
    localparam logic [63:0] W2 = 64'hDEADBEEFCAFEF00D;

    function automatic logic [31:0] exp_w(input logic [31:0] w);
`ifdef DMA_WR_BSWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    function automatic logic [31:0] lo(input logic [63:0] w);
        return exp_w(w[31:0]);
    endfunction

    function automatic logic [31:0] hi(input logic [63:0] w);
        return exp_w(w[63:32]);
    endfunction

    task automatic drive_fifo();
        i_fifo_empty = (fifo_q.size() == 0);
        i_fifo_dout  = (fifo_q.size() != 0) ? fifo_q[0] : 64'h0;
    endtask

    task automatic push(input logic [63:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    task automatic clear_log();
        pops = 0;
        done_cnt = 0;
        rd_empty_err = 0;
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        fifo_q.delete();
        drive_fifo();
    endtask

    // Sample outputs before the edge, apply FIFO pops / log writes just after it.
    task automatic tick();
        logic rd, xf, dn;
        logic [31:0] a, d;
        #1;
        rd = o_fifo_rd_en;
        xf = o_mem_req && i_mem_gnt;
        dn = o_done;
        a  = o_mem_addr;
        d  = o_mem_wdata;
        if (rd && i_fifo_empty) rd_empty_err++;
        @(posedge clk);
        cyc++;
        #1;
        if (rd && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            pops++;
        end
        if (xf) begin
            wr_addr.push_back(a);
            wr_data.push_back(d);
            wr_cyc.push_back(cyc);
        end
        if (dn) begin
            done_cnt++;
            done_cyc = cyc;
        end
        drive_fifo();
    endtask

    task automatic start(input logic [31:0] base, input logic [9:0] len);
        i_base_addr = base;
        i_len = len;
        i_start = 1'b1;
        tick();
        start_cyc = cyc;
        i_start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input string name);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == d0) $display("FAIL %s: no done pulse within %0d cycles", name, budget);
        else passed++;
    endtask

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        else passed++;
    endtask

    task automatic check_writes(input string name, input logic [31:0] ea[$], input logic [31:0] ed[$]);
        checks++;
        if (wr_addr.size() != ea.size()) begin
            $display("FAIL %s: write count %0d expected %0d", name, wr_addr.size(), ea.size());
            return;
        end
        foreach (ea[i]) begin
            if (wr_addr[i] !== ea[i] || wr_data[i] !== ed[i]) begin
                $display("FAIL %s: write %0d got (0x%08h,0x%08h) expected (0x%08h,0x%08h)",
                         name, i, wr_addr[i], wr_data[i], ea[i], ed[i]);
                return;
            end
        end
        passed++;
    endtask

    task automatic test_reset();
        #3;
        check_val("reset_outputs",
                  {25'd0, o_mem_req, o_busy, o_done, o_fifo_rd_en, 3'd0},
                  32'd0);
        check_val("reset_words_done", {22'd0, o_words_done}, 32'd0);
        check_val("reset_addr_wdata", o_mem_addr | o_mem_wdata, 32'd0);
        #4;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_packet();
        int fifo_before;
        clear_log();
        push(W0);
        push(W1);
        i_mem_gnt = 1'b0;
        start(32'h100, 10'd2);
        tick();
        check_val("mid_req_high", {31'd0, o_mem_req}, 32'd1);
        fifo_before = fifo_q.size();
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_req_busy", {30'd0, o_mem_req, o_busy}, 32'd0);
        tick();
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        check_val("mid_rst_no_done", done_cnt, 0);
        check_val("mid_rst_fifo_count", fifo_q.size(), fifo_before);
        i_mem_gnt = 1'b1;
    endtask

    task automatic test_single_word();
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        clear_log();
        push(W0);
        i_mem_gnt = 1'b1;
        start(32'h100, 10'd1);
        run_until_done(20, "single_done");
        ea = '{32'h100, 32'h104};
        ed = '{lo(W0), hi(W0)};
        check_writes("single_writes", ea, ed);
        check_val("single_latency", wr_cyc.size() > 0 ? wr_cyc[0] : -1, start_cyc + 2);
        check_val("single_done_timing", done_cyc, wr_cyc.size() > 1 ? wr_cyc[1] + 1 : -1);
        check_val("single_words_done", {22'd0, o_words_done}, 32'd1);
        check_val("single_pops", pops, 1);
        check_val("single_idle", {31'd0, o_busy}, 32'd0);
    endtask

    task automatic test_stall();
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        int stall = 0;
        int n = 0;
        int d0;
        clear_log();
        push(W0);
        push(W1);
        push(W2);
        i_mem_gnt = 1'b1;
        start(32'h100, 10'd3);
        d0 = done_cnt;
        while (done_cnt == d0 && n < 80) begin
            if (wr_addr.size() == 1 && stall < 4) begin
                i_mem_gnt = 1'b0;
                stall++;
                tick();
                checks++;
                if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h104 || o_mem_wdata !== hi(W0))
                    $display("FAIL stall_hold_%0d: req=%b addr=0x%08h data=0x%08h", stall,
                             o_mem_req, o_mem_addr, o_mem_wdata);
                else passed++;
            end else begin
                i_mem_gnt = 1'b1;
                tick();
            end
            n++;
        end
        i_mem_gnt = 1'b1;
        check_val("stall_done", done_cnt - d0, 1);
        check_val("stall_cycles", stall, 4);
        ea = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h114};
        ed = '{lo(W0), hi(W0), lo(W1), hi(W1), lo(W2), hi(W2)};
        check_writes("stall_writes", ea, ed);
        check_val("stall_pops", pops, 3);
        check_val("stall_words_done", {22'd0, o_words_done}, 32'd3);
    endtask

    task automatic test_fifo_empty();
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        int n = 0;
        int bad = 0;
        clear_log();
        push(W1);
        i_mem_gnt = 1'b1;
        start(32'h203, 10'd2);
        while (wr_addr.size() < 2 && n < 20) begin
            tick();
            n++;
        end
        check_val("empty_first_word", wr_addr.size(), 2);
        for (int i = 0; i < 5; i++) begin
            // A start pulse while busy must be ignored.
            if (i == 1) begin
                i_base_addr = 32'h800;
                i_len = 10'd5;
                i_start = 1'b1;
            end
            tick();
            i_start = 1'b0;
            if (o_fifo_rd_en !== 1'b0 || o_busy !== 1'b1 || o_mem_req !== 1'b0) bad++;
        end
        check_val("empty_wait_fetch", bad, 0);
        push(W2);
        run_until_done(20, "empty_done");
        ea = '{32'h200, 32'h204, 32'h208, 32'h20C};
        ed = '{lo(W1), hi(W1), lo(W2), hi(W2)};
        check_writes("empty_writes", ea, ed);
        check_val("empty_pops", pops, 2);
        check_val("empty_rd_while_empty", rd_empty_err, 0);
        check_val("empty_words_done", {22'd0, o_words_done}, 32'd2);
    endtask

    task automatic test_zero_len_and_wrap();
        logic [31:0] ea[$];
        logic [31:0] ed[$];
        clear_log();
        push(W2);
        i_mem_gnt = 1'b1;
        start(32'h300, 10'd0);
        run_until_done(5, "zero_done");
        check_val("zero_done_timing", done_cyc, start_cyc + 1);
        check_val("zero_no_writes", wr_addr.size(), 0);
        check_val("zero_no_pops", pops, 0);
        check_val("zero_words_done", {22'd0, o_words_done}, 32'd0);
        start(32'hFFFF_FFFC, 10'd1);
        run_until_done(20, "wrap_done");
        ea = '{32'hFFFF_FFFC, 32'h0000_0000};
        ed = '{lo(W2), hi(W2)};
        check_writes("wrap_writes", ea, ed);
        check_val("wrap_pops", pops, 1);
    endtask

    initial begin
        test_reset();
        test_reset_mid_packet();
        test_single_word();
        test_stall();
        test_fifo_empty();
        test_zero_len_and_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
